// File: rtl/bless_nic.sv
// bless_nic: network interface at the local port (port 4) of a bufferless
// BLESS router. Queues core flits for injection, captures every ejected flit
// into a buffer for the core, and keeps debug statistics.
module bless_nic #(
    parameter logic [3:0] NODE_ID   = 4'd0,
    parameter int         CTRL_W    = 16,
    parameter int         DATA_W    = 64,
    parameter int         INJ_DEPTH = 4,
    parameter int         EJ_DEPTH  = 4,
    parameter int         CNT_W     = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        in_dst,
    input  logic [DATA_W-1:0] in_data,
    output logic [CTRL_W-1:0] port4_ci,
    output logic [DATA_W-1:0] port4_di,
    input  logic              port4_ready,
    input  logic [CTRL_W-1:0] port4_co,
    input  logic [DATA_W-1:0] port4_do,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [3:0]        out_src,
    output logic [DATA_W-1:0] out_data,
    output logic [CNT_W-1:0]  inj_cnt,
    output logic [CNT_W-1:0]  drop_cnt,
    output logic [CNT_W-1:0]  misroute_cnt,
    output logic              ovf_sticky
);

    localparam int IAW = $clog2(INJ_DEPTH);
    localparam int EAW = $clog2(EJ_DEPTH);

    // ---------------- injection side ----------------
    logic [DATA_W+3:0] inj_mem [INJ_DEPTH];
    logic [IAW:0]      inj_wr;
    logic [IAW:0]      inj_rd;
    logic              inj_empty;
    logic              inj_full;
    logic              inj_push;
    logic              inj_pop;
    logic              slot_accept;
    logic              slot_load;
    logic [DATA_W+3:0] inj_head;
    logic [CTRL_W-1:0] ctrl_fmt;

    assign inj_empty   = (inj_wr == inj_rd);
    assign inj_full    = (inj_wr[IAW] != inj_rd[IAW]) &&
                         (inj_wr[IAW-1:0] == inj_rd[IAW-1:0]);
    assign in_ready    = !inj_full;
    assign inj_push    = in_valid && !inj_full;
    assign slot_accept = port4_ci[15] && port4_ready;
    // The slot refills whenever it is empty or being handed to the router.
    assign slot_load   = !port4_ci[15] || slot_accept;
    assign inj_pop     = slot_load && !inj_empty;
    assign inj_head    = inj_mem[inj_rd[IAW-1:0]];

    // Format the control word for the FIFO head: valid, age 0, dst, our id
    always_comb begin
        ctrl_fmt       = '0;
        ctrl_fmt[15]   = 1'b1;
        ctrl_fmt[7:4]  = inj_head[DATA_W+3:DATA_W];
        ctrl_fmt[3:0]  = NODE_ID;
    end

    // Injection FIFO storage
    always_ff @(posedge clk) begin
        if (inj_push)
            inj_mem[inj_wr[IAW-1:0]] <= {in_dst, in_data};
    end

    // Injection FIFO pointers
    always_ff @(posedge clk) begin
        if (rst) begin
            inj_wr <= '0;
            inj_rd <= '0;
        end else begin
            if (inj_push) inj_wr <= inj_wr + 1'b1;
            if (inj_pop)  inj_rd <= inj_rd + 1'b1;
        end
    end

    // Output register presented to the router; holds until accepted
    always_ff @(posedge clk) begin
        if (rst) begin
            port4_ci <= '0;
            port4_di <= '0;
        end else if (slot_load) begin
            if (!inj_empty) begin
                port4_ci <= ctrl_fmt;
                port4_di <= inj_head[DATA_W-1:0];
            end else begin
                port4_ci <= '0;
                port4_di <= '0;
            end
        end
    end

    // ---------------- ejection side ----------------
    logic [DATA_W+3:0] ej_mem [EJ_DEPTH];
    logic [EAW:0]      ej_wr;
    logic [EAW:0]      ej_rd;
    logic              ej_empty;
    logic              ej_full;
    logic              ej_pop;
    logic              ej_push;
    logic              ej_drop;
    logic              cap;
    logic              dst_ok;
    logic              misroute;
    logic              unused_co;

    assign ej_empty  = (ej_wr == ej_rd);
    assign ej_full   = (ej_wr[EAW] != ej_rd[EAW]) &&
                       (ej_wr[EAW-1:0] == ej_rd[EAW-1:0]);
    assign cap       = port4_co[15];
    assign dst_ok    = (port4_co[7:4] == NODE_ID);
    assign ej_pop    = !ej_empty && out_ready;
    // A full FIFO still accepts a capture when the core pops in the same cycle.
    assign ej_push   = cap && dst_ok && (!ej_full || ej_pop);
    assign ej_drop   = cap && dst_ok && ej_full && !ej_pop;
    assign misroute  = cap && !dst_ok;
    assign out_valid = !ej_empty;
    assign {out_src, out_data} = ej_mem[ej_rd[EAW-1:0]];
    // Age and any upper control bits are not needed on the ejection side.
    assign unused_co = ^port4_co;

    // Ejection FIFO storage
    always_ff @(posedge clk) begin
        if (ej_push)
            ej_mem[ej_wr[EAW-1:0]] <= {port4_co[3:0], port4_do};
    end

    // Ejection FIFO pointers
    always_ff @(posedge clk) begin
        if (rst) begin
            ej_wr <= '0;
            ej_rd <= '0;
        end else begin
            if (ej_push) ej_wr <= ej_wr + 1'b1;
            if (ej_pop)  ej_rd <= ej_rd + 1'b1;
        end
    end

    // Saturating statistics counters and overflow flag
    always_ff @(posedge clk) begin
        if (rst) begin
            inj_cnt      <= '0;
            drop_cnt     <= '0;
            misroute_cnt <= '0;
            ovf_sticky   <= 1'b0;
        end else begin
            if (slot_accept && inj_cnt != '1)     inj_cnt      <= inj_cnt + 1'b1;
            if (ej_drop && drop_cnt != '1)        drop_cnt     <= drop_cnt + 1'b1;
            if (misroute && misroute_cnt != '1)   misroute_cnt <= misroute_cnt + 1'b1;
            if (ej_drop)                          ovf_sticky   <= 1'b1;
        end
    end

endmodule

// File: doc/bless_nic.md
Name: bless_nic

Overview:
- Node-side network interface at the local port (port 4) of the bufferless BLESS router.
- Injection path: accepts flits from the core over valid/ready, queues them, formats the control word, and presents them to the router's injection input, holding each flit until the router signals a free slot.
- Ejection path: captures every flit the router ejects (the router cannot be backpressured), buffers it, and hands it to the core over valid/ready.
- Drop, misroute and injection statistics are kept for debug.

Parameters:
- NODE_ID, 0: this node's 4-bit id; written into the src field and checked against the dst field.
- CTRL_W, 16: control word width.
- DATA_W, 64: flit payload width.
- INJ_DEPTH, 4: injection FIFO entries (power of 2, at least 2).
- EJ_DEPTH, 4: ejection FIFO entries (power of 2, at least 2).
- CNT_W, 16: statistics counter width.

Ports:
- clk  in  1  clock, all state on rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  core flit valid.
- in_ready  out  1  injection FIFO not full.
- in_dst  in  4  destination node id.
- in_data  in  DATA_W  payload.
- port4_ci  out  CTRL_W  control word to router injection input.
- port4_di  out  DATA_W  data to router injection input.
- port4_ready  in  1  router accepts the presented flit at this edge.
- port4_co  in  CTRL_W  control word ejected by router.
- port4_do  in  DATA_W  data ejected by router.
- out_valid  out  1  ejected flit available to core.
- out_ready  in  1  core accepts the ejected flit.
- out_src  out  4  source id of the ejected flit.
- out_data  out  DATA_W  ejected payload.
- inj_cnt  out  CNT_W  flits accepted by the router, saturating.
- drop_cnt  out  CNT_W  flits lost to ejection overflow, saturating.
- misroute_cnt  out  CNT_W  flits ejected with dst != NODE_ID, saturating.
- ovf_sticky  out  1  set on any drop, cleared only by reset.

Behaviour:
- Control word format:
  - bit 15: valid.
  - bits 14:8: age. The NIC injects age 0; the router increments it.
  - bits 7:4: dst.
  - bits 3:0: src.
  - Bits above 15 (when CTRL_W > 16) are driven 0.
- Reset (rst=1 at an edge) takes effect at that edge:
  - Both FIFOs emptied; the output register is cleared.
  - port4_ci=0, port4_di=0, out_valid=0, in_ready=1.
  - All counters are 0; ovf_sticky=0.
  - A flit being presented or ejected at that edge is discarded.
- Injection FIFO:
  - Push on the edge where in_valid && in_ready.
  - Entry stored: {dst=in_dst, payload=in_data}.
  - in_ready = !inj_full (combinational from registered state).
- Injection output register (holds one flit):
  - When empty, or when its flit is accepted this edge (port4_ci[15] && port4_ready), it loads the FIFO head if one exists and pops it. Otherwise it becomes invalid.
  - Result: one flit per cycle back-to-back while port4_ready stays 1.
  - Minimum latency: an in_valid accept at edge N puts the flit on port4_ci at edge N+1.
  - While port4_ready=0, port4_ci/port4_di stay stable.
  - When invalid, port4_ci=0 and port4_di=0.
  - inj_cnt increments on each accept.
- Loopback: in_dst == NODE_ID is injected normally.
- Ejection capture (every edge where port4_co[15]=1):
  - If port4_co[7:4] != NODE_ID: the flit is discarded and misroute_cnt increments.
  - Otherwise it is pushed as {src, data}.
  - If the FIFO is full and no pop happens this edge: the flit is dropped, drop_cnt increments and ovf_sticky is set.
  - Push to a full FIFO with a simultaneous pop (out_valid && out_ready): both happen, no drop.
- Core side of ejection:
  - out_valid = !ej_empty.
  - out_src and out_data show the FIFO head.
  - Pop on out_valid && out_ready.
  - A capture at edge N appears on out_valid after edge N (one-cycle latency).
- FIFO pointers wrap modulo depth.
- Full and empty are distinguished by an extra pointer bit.
- All counters saturate at all-ones.

Test Plan:
- Reset then idle: port4_ci=0000, out_valid=0, in_ready=1, all counters 0.
- NODE_ID=3, inject dst=5, data=0123456789abcdef with port4_ready=1:
  - Next cycle port4_ci=8053, port4_di=0123456789abcdef.
  - Accepted at following edge; inj_cnt=1.
- port4_ready=0 for 5 cycles with 6 flits offered:
  - in_ready drops after 5 accepts (4 in FIFO + 1 in the output register).
  - port4_ci stays stable for those 5 cycles.
  - Raising port4_ready drains all 5 in consecutive cycles, in order.
- Eject port4_co=8a37 (age 0a, dst 3, src 7) with out_ready=1:
  - out_valid next cycle, out_src=7, payload matches.
- out_ready=0, eject 6 valid flits to NODE_ID on consecutive cycles:
  - 4 stored, drop_cnt=2, ovf_sticky=1.
  - A 7th push coincident with out_ready=1 is stored with no further drop.
- Eject port4_co=8052 at NODE_ID=3: misroute_cnt=1, out_valid stays 0.
- Assert rst mid-burst with both FIFOs partly full: all outputs return to reset values at that edge.
